// File: rtl/pipe_skid_reg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pipe_skid_reg                                              |
// | Description : Pipeline stage register with optional 2-entry skid buffer. |
// |               Carries a payload and control bits, supports flush with    |
// |               a saturating discarded-beat counter.                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pipe_skid_reg #(
  parameter int DATA_W  = 64,
  parameter int CTRL_W  = 8,
  parameter int SKID_EN = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [7:0]        flush_count
);

  // State encoding doubles as the held-beat count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [7:0]          flush_count_q, flush_count_d;

  logic                in_fire;
  logic                out_fire;
  logic [1:0]          drop;
  logic [8:0]          fc_sum;

  // Outputs come straight from the main register; a bubble carries no control bits.
  assign out_valid   = (state_q != ST_EMPTY);
  assign out_data    = main_data_q;
  assign out_ctrl    = out_valid ? main_ctrl_q : '0;
  assign occupancy   = state_q;
  assign flush_count = flush_count_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Upstream ready: registered-only in skid mode, pass-through in single-entry mode; low in reset.
  always_comb begin
    in_ready = 1'b0;
    if (SKID_EN != 0) begin
      in_ready = reset_n & ~flush & (state_q != ST_TWO);
    end else begin
      in_ready = reset_n & ~flush & (~out_valid | out_ready);
    end
  end

  // Next-state, storage and flush-counter update; flush overrides all traffic.
  always_comb begin
    state_d       = state_q;
    main_data_d   = main_data_q;
    main_ctrl_d   = main_ctrl_q;
    skid_data_d   = skid_data_q;
    skid_ctrl_d   = skid_ctrl_q;
    flush_count_d = flush_count_q;
    drop          = 2'd0;
    fc_sum        = 9'd0;

    if (flush) begin
      state_d       = ST_EMPTY;
      // A beat handed downstream on the flush edge was delivered, not discarded.
      drop          = occupancy - {1'b0, out_fire};
      fc_sum        = {1'b0, flush_count_q} + {7'd0, drop};
      flush_count_d = fc_sum[8] ? 8'hFF : fc_sum[7:0];
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d     = ST_ONE;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (in_fire) begin
            // Only reachable in skid mode; single-entry mode never accepts while stalled.
            if (SKID_EN != 0) begin
              state_d     = ST_TWO;
              skid_data_d = in_data;
              skid_ctrl_d = in_ctrl;
            end
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            state_d     = ST_ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // State and storage registers with asynchronous clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_EMPTY;
      main_data_q   <= '0;
      main_ctrl_q   <= '0;
      skid_data_q   <= '0;
      skid_ctrl_q   <= '0;
      flush_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      main_data_q   <= main_data_d;
      main_ctrl_q   <= main_ctrl_d;
      skid_data_q   <= skid_data_d;
      skid_ctrl_q   <= skid_ctrl_d;
      flush_count_q <= flush_count_d;
    end
  end

endmodule
`default_nettype wire
